// File: rtl/eth_demux_pkg.sv
// Shared definitions for the Ethernet RX demultiplexer: parameter defaults,
// FSM state encoding, the broadcast address and an index-width helper.
package eth_demux_pkg;

    localparam int DEF_NUM_PORTS  = 3;
    localparam int DEF_DATA_W     = 256;
    localparam int DEF_CNT_W      = 32;
    localparam int DEF_BCAST_PORT = 0;

    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } demux_state_e;

    // Port index width; a single port still needs one bit to index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/eth_rx_dst_lookup.sv
// Combinational destination lookup. The broadcast address always goes to
// BCAST_PORT, and only if that port is enabled. Any other address picks the
// lowest-index enabled port whose MAC matches.
module eth_rx_dst_lookup
    import eth_demux_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int BCAST_PORT = DEF_BCAST_PORT,
    localparam int IDX_W     = idx_width(NUM_PORTS)
) (
    input  logic [47:0]      dst,
    input  logic [47:0]      cfg_port_mac [NUM_PORTS],
    input  logic             cfg_port_en  [NUM_PORTS],
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    // Priority match. The loop descends so that the lowest index wins.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        if (dst == BCAST_MAC) begin
            hit = cfg_port_en[BCAST_PORT];
            idx = IDX_W'(BCAST_PORT);
        end else begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (cfg_port_en[i] && (cfg_port_mac[i] == dst)) begin
                    hit = 1'b1;
                    idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/eth_rx_demux.sv
// Ethernet RX demultiplexer: steers MAC-side packets to one of NUM_PORTS NIC
// ports by destination MAC, through a single shared output register.
// Optional build macro ETH_RX_DEMUX_STATS_EN compiles in the saturating
// statistics counters; without it the stat_* outputs are tied to zero.
//
//   state | meaning
//   IDLE  | waiting for a sop beat; non-sop beats are discarded
//   FWD   | forwarding the current packet to the latched port
//   DROP  | consuming the current packet with in_ready held high
module eth_rx_demux
    import eth_demux_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int BCAST_PORT = DEF_BCAST_PORT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [47:0]       cfg_port_mac [NUM_PORTS],
    input  logic              cfg_port_en  [NUM_PORTS],
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [4:0]        in_empty,
    input  logic [5:0]        in_error,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic [4:0]        out_empty,
    output logic [5:0]        out_error,
    output logic              out_valid [NUM_PORTS],
    input  logic              out_ready [NUM_PORTS],
    output logic [CNT_W-1:0]  stat_pkt_cnt [NUM_PORTS],
    output logic [CNT_W-1:0]  stat_drop_cnt,
    output logic [CNT_W-1:0]  stat_proto_err_cnt
);

    localparam int IDX_W = idx_width(NUM_PORTS);

    demux_state_e     state_q;
    logic [IDX_W-1:0] out_port_q;   // port of the register contents, also the latched destination
    logic             out_full_q;
    logic             ready_en_q;   // keeps in_ready low during reset and for the first cycle after
    logic             lk_hit;
    logic [IDX_W-1:0] lk_idx;
    logic             sel_ready;
    logic             drain;
    logic             accept;
    logic             fwd_beat;
    logic [IDX_W-1:0] load_port;

    eth_rx_dst_lookup #(
        .NUM_PORTS  (NUM_PORTS),
        .BCAST_PORT (BCAST_PORT)
    ) u_lookup (
        .dst          (in_data[DATA_W-1 -: 48]),
        .cfg_port_mac (cfg_port_mac),
        .cfg_port_en  (cfg_port_en),
        .hit          (lk_hit),
        .idx          (lk_idx)
    );

    // Readiness of the port that currently owns the output register.
    always_comb begin
        sel_ready = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (out_port_q == IDX_W'(i)) sel_ready = out_ready[i];
        end
    end

    assign drain = out_full_q && sel_ready;

    // Upstream ready. The register may be refilled in the same cycle it drains.
    // IDLE is gated the same way because a sop beat may need the register.
    always_comb begin
        in_ready = 1'b0;
        if (ready_en_q) begin
            in_ready = (state_q == DROP) ? 1'b1 : (!out_full_q || sel_ready);
        end
    end

    assign accept    = in_valid && in_ready;
    assign fwd_beat  = accept && (((state_q == IDLE) && in_sop && lk_hit) || (state_q == FWD));
    assign load_port = (state_q == IDLE) ? lk_idx : out_port_q;

    // Packet FSM and output register; destination is latched only on the sop beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            out_port_q <= '0;
            out_full_q <= 1'b0;
            ready_en_q <= 1'b0;
            out_data   <= '0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_empty  <= '0;
            out_error  <= '0;
            for (int i = 0; i < NUM_PORTS; i++) out_valid[i] <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (fwd_beat) begin
                out_data   <= in_data;
                out_sop    <= in_sop;
                out_eop    <= in_eop;
                out_empty  <= in_empty;
                out_error  <= in_error;
                out_full_q <= 1'b1;
                out_port_q <= load_port;
                for (int i = 0; i < NUM_PORTS; i++) out_valid[i] <= (load_port == IDX_W'(i));
            end else if (drain) begin
                out_full_q <= 1'b0;
                for (int i = 0; i < NUM_PORTS; i++) out_valid[i] <= 1'b0;
            end
            if (accept) begin
                case (state_q)
                    IDLE: begin
                        if (in_sop && !in_eop) state_q <= lk_hit ? FWD : DROP;
                    end
                    FWD, DROP: begin
                        if (in_eop) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef ETH_RX_DEMUX_STATS_EN
    logic [CNT_W-1:0] pkt_cnt_q [NUM_PORTS];
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0] proto_cnt_q;
    logic             drop_inc;
    logic             proto_inc;

    // A packet is dropped at its sop; a protocol error is a missing or a stray sop.
    assign drop_inc  = accept && (state_q == IDLE) && in_sop && !lk_hit;
    assign proto_inc = accept && (((state_q == IDLE) && !in_sop) || ((state_q != IDLE) && in_sop));

    // Saturating statistics; packets count when their eop beat leaves the register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PORTS; i++) pkt_cnt_q[i] <= '0;
            drop_cnt_q  <= '0;
            proto_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (drain && out_eop && (out_port_q == IDX_W'(i)) && (pkt_cnt_q[i] != '1))
                    pkt_cnt_q[i] <= pkt_cnt_q[i] + CNT_W'(1);
            end
            if (drop_inc && (drop_cnt_q != '1))   drop_cnt_q  <= drop_cnt_q + CNT_W'(1);
            if (proto_inc && (proto_cnt_q != '1)) proto_cnt_q <= proto_cnt_q + CNT_W'(1);
        end
    end

    assign stat_pkt_cnt       = pkt_cnt_q;
    assign stat_drop_cnt      = drop_cnt_q;
    assign stat_proto_err_cnt = proto_cnt_q;
`else
    // Statistics are not built in this configuration.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) stat_pkt_cnt[i] = '0;
        stat_drop_cnt      = '0;
        stat_proto_err_cnt = '0;
    end
`endif

endmodule

// File: tb/tb_eth_rx_demux.sv
// Directed bench for eth_rx_demux: a table of one-beat packets followed by
// hand-written multi-cycle sequences. Statistics expectations collapse to zero
// when the design is built without ETH_RX_DEMUX_STATS_EN.
module tb_eth_rx_demux;

    localparam int NP = 3;
    localparam int DW = 256;
    localparam int CW = 4;
`ifdef ETH_RX_DEMUX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [47:0] M0 = 48'h0200_0000_0000;
    localparam logic [47:0] M1 = 48'h0200_0000_0001;
    localparam logic [47:0] M2 = 48'h0200_0000_0002;
    localparam logic [47:0] M9 = 48'h0200_0000_0009;
    localparam logic [47:0] BC = 48'hFFFF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [47:0]   cfg_port_mac [NP];
    logic          cfg_port_en  [NP];
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
    logic [4:0]    in_empty = '0;
    logic [5:0]    in_error = '0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_sop, out_eop;
    logic [4:0]    out_empty;
    logic [5:0]    out_error;
    logic          out_valid [NP];
    logic          out_ready [NP];
    logic [CW-1:0] stat_pkt_cnt [NP];
    logic [CW-1:0] stat_drop_cnt, stat_proto_err_cnt;

    int tests = 0;
    int fails = 0;
    int multi_err = 0;
    int log_q[$];   // delivered beats: port*1024 + eop*256 + tag
    int exp_q[$];

    eth_rx_demux #(
        .NUM_PORTS (NP), .DATA_W (DW), .CNT_W (CW), .BCAST_PORT (0)
    ) dut (
        .clk (clk), .reset_n (reset_n),
        .cfg_port_mac (cfg_port_mac), .cfg_port_en (cfg_port_en),
        .in_data (in_data), .in_valid (in_valid), .in_sop (in_sop), .in_eop (in_eop),
        .in_empty (in_empty), .in_error (in_error), .in_ready (in_ready),
        .out_data (out_data), .out_sop (out_sop), .out_eop (out_eop),
        .out_empty (out_empty), .out_error (out_error),
        .out_valid (out_valid), .out_ready (out_ready),
        .stat_pkt_cnt (stat_pkt_cnt), .stat_drop_cnt (stat_drop_cnt),
        .stat_proto_err_cnt (stat_proto_err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Record every output transfer and flag more than one valid at a time.
    always @(negedge clk) begin
        int nv;
        nv = 0;
        if (reset_n) begin
            for (int p = 0; p < NP; p++) begin
                if (out_valid[p]) begin
                    nv++;
                    if (out_ready[p]) log_q.push_back(p * 1024 + (out_eop ? 256 : 0) + int'(out_data[7:0]));
                end
            end
            if (nv > 1) multi_err++;
        end
    end

    function automatic int se(input int v);
        return STATS ? v : 0;
    endfunction

    function automatic logic [2:0] ov();
        return {out_valid[2], out_valid[1], out_valid[0]};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_log(input string name);
        check({name, "_count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < log_q.size()) check($sformatf("%s_beat%0d", name, i), log_q[i], exp_q[i]);
        end
    endtask

    // Present one beat and hold it until accepted; returns one step after the accepting edge.
    task automatic send_beat(input logic [47:0] dst, input logic [7:0] tag, input logic sop, input logic eop);
        int waited;
        waited = 0;
        in_data  = {dst, 200'd0, tag};
        in_sop   = sop;
        in_eop   = eop;
        in_error = tag[5:0];
        in_empty = tag[4:0];
        in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) check("ready_wait", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        reset_n  = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [47:0] dst;
        logic [2:0]  en;
        logic [47:0] mac2;
        int          exp_port;   // -1: dropped
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    initial begin
        int  pkt_exp [NP];
        int  drop_exp;
        int  b;
        logic rdy;
        bit  orp [6];
        bit  exp_rdy [6];
        logic [7:0] tag;
        logic [2:0] exp_ov;

        vecs[0]  = '{M0, 3'b111, M2,  0};
        vecs[1]  = '{M1, 3'b111, M2,  1};
        vecs[2]  = '{M2, 3'b111, M2,  2};
        vecs[3]  = '{M9, 3'b111, M2, -1};
        vecs[4]  = '{M2, 3'b011, M2, -1};
        vecs[5]  = '{M1, 3'b111, M1,  1};
        vecs[6]  = '{M1, 3'b101, M1,  2};
        vecs[7]  = '{BC, 3'b110, M2, -1};
        vecs[8]  = '{BC, 3'b111, M2,  0};
        vecs[9]  = '{BC, 3'b001, M2,  0};
        vecs[10] = '{M0, 3'b110, M2, -1};

        cfg_port_mac[0] = M0; cfg_port_mac[1] = M1; cfg_port_mac[2] = M2;
        for (int i = 0; i < NP; i++) begin
            cfg_port_en[i] = 1'b1;
            out_ready[i]   = 1'b1;
        end

        // Reset state, sampled while reset is still asserted.
        @(posedge clk); #1;
        check("rst_out_valid", ov(), 3'b000);
        check("rst_in_ready", in_ready, 0);
        check("rst_pkt_cnt1", stat_pkt_cnt[1], 0);
        check("rst_drop_cnt", stat_drop_cnt, 0);
        #3 reset_n = 1'b1;
        idle(1);

        // One-beat packets from the table.
        for (int i = 0; i < NP; i++) pkt_exp[i] = 0;
        drop_exp = 0;
        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < NP; i++) cfg_port_en[i] = vecs[v].en[i];
            cfg_port_mac[2] = vecs[v].mac2;
            tag = 8'(8'h40 + v);
            send_beat(vecs[v].dst, tag, 1'b1, 1'b1);
            exp_ov = (vecs[v].exp_port < 0) ? 3'b000 : 3'(1 << vecs[v].exp_port);
            check($sformatf("vec%0d_out_valid", v), ov(), exp_ov);
            if (vecs[v].exp_port >= 0) begin
                check($sformatf("vec%0d_payload", v), {out_empty, out_error, out_eop, out_data[7:0]},
                      {tag[4:0], tag[5:0], 1'b1, tag});
                pkt_exp[vecs[v].exp_port]++;
            end else begin
                drop_exp++;
            end
            idle(1);
        end
        idle(2);
        for (int i = 0; i < NP; i++) check($sformatf("vec_pkt_cnt%0d", i), stat_pkt_cnt[i], se(pkt_exp[i]));
        check("vec_drop_cnt", stat_drop_cnt, se(drop_exp));
        cfg_port_mac[2] = M2;
        for (int i = 0; i < NP; i++) cfg_port_en[i] = 1'b1;

        // Three-beat packet to port 1, one-cycle latency; cfg changed mid-packet.
        do_reset();
        log_q.delete();
        send_beat(M1, 8'h10, 1'b1, 1'b0);
        check("p3_lat_b0", {ov(), out_data[7:0]}, {3'b010, 8'h10});
        cfg_port_en[1] = 1'b0;
        cfg_port_mac[1] = M9;
        send_beat(M1, 8'h11, 1'b0, 1'b0);
        check("p3_lat_b1", {ov(), out_data[7:0]}, {3'b010, 8'h11});
        send_beat(M1, 8'h12, 1'b0, 1'b1);
        check("p3_lat_b2", {ov(), out_data[7:0], out_eop}, {3'b010, 8'h12, 1'b1});
        idle(1);
        check("p3_idle_after", ov(), 3'b000);
        cfg_port_en[1] = 1'b1;
        cfg_port_mac[1] = M1;
        idle(1);
        exp_q.delete();
        exp_q.push_back(1024 + 8'h10); exp_q.push_back(1024 + 8'h11); exp_q.push_back(1024 + 256 + 8'h12);
        check_log("p3_log");
        check("p3_pkt_cnt1", stat_pkt_cnt[1], se(1));

        // Unknown MAC: dropped, in_ready high on every beat.
        do_reset();
        log_q.delete();
        rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = {M9, 200'd0, 8'(8'h18 + k)};
            in_sop = (k == 0); in_eop = (k == 2); in_valid = 1'b1;
            #1 rdy = rdy & in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        idle(2);
        check("drop_ready_high", rdy, 1);
        check("drop_no_output", log_q.size(), 0);
        check("drop_cnt", stat_drop_cnt, se(1));

        // Backpressure on port 2: out_ready 1,0,0,1 during a 4-beat packet.
        do_reset();
        log_q.delete();
        orp     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        b = 0;
        for (int c = 0; c < 6; c++) begin
            in_data = {M2, 200'd0, 8'(8'h20 + b)};
            in_sop = (b == 0); in_eop = (b == 3); in_valid = (b < 4);
            out_ready[2] = orp[c];
            #3;
            check($sformatf("bp_in_ready_c%0d", c), in_ready, exp_rdy[c]);
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy && b < 4) b++;
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        out_ready[2] = 1'b1;
        idle(3);
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back(2048 + (k == 3 ? 256 : 0) + 8'h20 + k);
        check_log("bp_log");

        // Protocol errors: stray non-sop beat in IDLE, then sop inside a packet.
        do_reset();
        log_q.delete();
        send_beat(M0, 8'h30, 1'b0, 1'b1);
        send_beat(M0, 8'h31, 1'b1, 1'b1);
        send_beat(M1, 8'h32, 1'b1, 1'b0);
        send_beat(M1, 8'h33, 1'b1, 1'b0);
        send_beat(M1, 8'h34, 1'b0, 1'b1);
        idle(3);
        exp_q.delete();
        exp_q.push_back(256 + 8'h31);
        exp_q.push_back(1024 + 8'h32); exp_q.push_back(1024 + 8'h33); exp_q.push_back(1024 + 256 + 8'h34);
        check_log("proto_log");
        check("proto_cnt", stat_proto_err_cnt, se(2));
        check("proto_pkt_cnt0", stat_pkt_cnt[0], se(1));
        for (int k = 0; k < 16; k++) send_beat(M0, 8'h60, 1'b0, 1'b0);
        idle(2);
        check("proto_saturate", stat_proto_err_cnt, se(15));
        check("proto_sat_nothing_fwd", log_q.size(), 4);

        // Reset in the middle of a 4-beat packet.
        do_reset();
        send_beat(M1, 8'h40, 1'b1, 1'b0);
        send_beat(M1, 8'h41, 1'b0, 1'b0);
        check("rstmid_before", ov(), 3'b010);
        in_data = {M1, 200'd0, 8'h42}; in_valid = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check("rstmid_out_valid", ov(), 3'b000);
        check("rstmid_in_ready", in_ready, 0);
        do_reset();
        log_q.delete();
        send_beat(M2, 8'h50, 1'b1, 1'b0);
        send_beat(M2, 8'h51, 1'b0, 1'b1);
        idle(3);
        exp_q.delete();
        exp_q.push_back(2048 + 8'h50); exp_q.push_back(2048 + 256 + 8'h51);
        check_log("rstmid_log");
        check("rstmid_pkt_cnt1", stat_pkt_cnt[1], 0);
        check("rstmid_pkt_cnt2", stat_pkt_cnt[2], se(1));

        check("one_valid_at_a_time", multi_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/eth_rx_demux.md
ETH_RX_DEMUX -- requirements
Module: eth_rx_demux

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3: number of NIC RX ports.
REQ-002 SHALL have parameter DATA_W, default 256: stream data width.
REQ-003 SHALL have parameter CNT_W, default 32: statistics counter width.
REQ-004 SHALL have parameter BCAST_PORT, default 0: destination of broadcast frames.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port clk, input, 1: sole clock, all logic on its rising edge.
REQ-007 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have ports cfg_port_mac [NUM_PORTS], input, 48 each: per-port destination MAC.
REQ-009 SHALL have ports cfg_port_en [NUM_PORTS], input, 1 each: per-port enable.
REQ-010 SHALL have MAC-side input ports in_data (DATA_W), in_valid, in_sop, in_eop (1 each), in_empty (5) and in_error (6), plus output in_ready (1).
REQ-011 SHALL have shared NIC-side output ports out_data (DATA_W), out_sop, out_eop (1 each), out_empty (5) and out_error (6).
REQ-012 SHALL have out_valid [NUM_PORTS] as outputs and out_ready [NUM_PORTS] as inputs, 1 bit each.
REQ-013 SHALL have outputs stat_pkt_cnt [NUM_PORTS], stat_drop_cnt and stat_proto_err_cnt, CNT_W each.

Function
REQ-014 Handshake SHALL be ready/valid, ready latency 0; a beat transfers when valid && ready are both high in the same cycle.
REQ-015 FSM states SHALL be IDLE, FWD and DROP.
REQ-016 In IDLE, an accepted sop beat SHALL select the destination from the dst MAC field, in_data[DATA_W-1 -: 48].
REQ-017 Selection SHALL pick the lowest index i with cfg_port_mac[i] equal to dst and cfg_port_en[i] high.
REQ-018 A dst of FF:FF:FF:FF:FF:FF SHALL go to BCAST_PORT if that port is enabled, otherwise it SHALL be dropped.
REQ-019 A packet with no enabled match SHALL enter DROP; it is consumed with in_ready held at 1 and never presented on any output.
REQ-020 Destination and cfg SHALL be sampled only on the sop beat and held until eop; cfg changes mid-packet SHALL NOT affect that packet.
REQ-021 Accepted beats SHALL pass through one output register; latency SHALL be exactly 1 cycle from acceptance to out_valid.
REQ-022 out_valid SHALL be asserted only for the latched destination, one port at a time.
REQ-023 In FWD, in_ready SHALL equal !out_reg_full || out_ready[dest], giving full throughput with no bubbles.
REQ-024 The eop beat SHALL return the FSM to IDLE (from FWD or DROP); a beat with both sop and eop SHALL form a one-beat packet.
REQ-025 A beat accepted in IDLE without sop SHALL be discarded and SHALL increment stat_proto_err_cnt.
REQ-026 A sop beat arriving in FWD or DROP SHALL be treated as data (forwarded or dropped with its packet) and SHALL increment stat_proto_err_cnt.
REQ-027 in_error SHALL be passed through unchanged and SHALL NOT influence steering.
REQ-028 stat_pkt_cnt[i] SHALL increment on each eop beat delivered to port i.
REQ-029 stat_drop_cnt SHALL increment once per packet that enters DROP.
REQ-030 All counters SHALL saturate at 2^CNT_W-1.

Reset
REQ-031 reset_n low SHALL immediately clear the FSM to IDLE, out_valid to 0, in_ready to 0, the output register and all counters.
REQ-032 A packet in flight at reset SHALL be lost.
REQ-033 After reset release, the first accepted beat SHALL be treated per IDLE rules.

Configuration
REQ-034 The statistics counters SHALL be compiled in only when macro ETH_RX_DEMUX_STATS_EN is defined.
REQ-035 Without ETH_RX_DEMUX_STATS_EN, all stat_* outputs SHALL be constant 0 and no counter flops SHALL exist; steering SHALL be unchanged.

Structure
REQ-036 Parameter defaults, the FSM state enum and the broadcast MAC constant SHALL reside in shared package eth_demux_pkg.
REQ-037 The destination lookup SHALL be sub-module eth_rx_dst_lookup: combinational, taking dst, cfg_port_mac and cfg_port_en, returning hit and index.

Verification
REQ-038 Ports 0/1/2 are configured to MACs 02:00:00:00:00:0{0,1,2}; a 3-beat packet to :01 SHALL produce exactly 3 beats on out_valid[1], 1 cycle later, and stat_pkt_cnt[1]=1.
REQ-039 A packet to unknown MAC 02:00:00:00:00:09 SHALL produce no out_valid, keep in_ready=1 throughout, and give stat_drop_cnt=1.
REQ-040 A broadcast packet with port 0 disabled SHALL be dropped; with port 0 enabled it SHALL be delivered on port 0.
REQ-041 With out_ready[2] toggled 1,0,0,1 during a 4-beat packet, no beat SHALL be lost or duplicated and in_ready SHALL track out_ready.
REQ-042 A non-sop beat in IDLE SHALL give stat_proto_err_cnt=1 with nothing forwarded; a following sop+eop one-beat packet SHALL be delivered normally.
REQ-043 Asserting reset_n=0 on beat 2 of a 4-beat packet SHALL drop out_valid at once; after release, a new packet SHALL forward correctly.
